// File: rtl/sample_deserializer.sv
// sample_deserializer: gathers 8 serial DW-bit samples into one parallel block.
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   din holds a valid serial sample
//   din        serial sample; block element 0 arrives first
//   in_ready   block accepts din this cycle
//   out_valid  dout0..dout7 hold a complete block
//   out_ready  downstream consumes the block this cycle
//   dout0..7   parallel block; dout0 is the first sample received
//   blk_cnt    delivered-block count, present only with DESER_BLKCNT_EN
module sample_deserializer #(
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] din,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] dout0,
   output logic [DW-1:0] dout1,
   output logic [DW-1:0] dout2,
   output logic [DW-1:0] dout3,
   output logic [DW-1:0] dout4,
   output logic [DW-1:0] dout5,
   output logic [DW-1:0] dout6,
   output logic [DW-1:0] dout7
`ifdef DESER_BLKCNT_EN
   ,
   output logic [15:0]   blk_cnt
`endif
);
   localparam int N = 8;
   typedef enum logic {FILL, HOLD} state_t;
   state_t state, state_nxt;
   logic [2:0] idx;
   logic [DW-1:0] shadow [N];
   logic [DW-1:0] dout [N];
   logic slot_free, accept, last, load_in, load_hold;
   assign slot_free = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign last      = accept && idx == 3'd7;
   // 8th sample bypasses shadow[7] straight into the output register
   assign load_in   = last && slot_free;
   assign load_hold = state == HOLD && slot_free;
   always_ff @(posedge clk)
      state <= reset ? FILL : state_nxt;
   always_comb
      state_nxt = (last && !slot_free) ? HOLD : load_hold ? FILL : state;
   always_comb
      in_ready = state == FILL;
   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         out_valid <= 1'b0;
         shadow    <= '{default: '0};
         dout      <= '{default: '0};
      end else begin
         if (accept) begin
            shadow[idx] <= din;
            idx         <= idx + 3'd1;
         end
         if (load_in) begin
            for (int i = 0; i < N - 1; i++) dout[i] <= shadow[i];
            dout[N-1] <= din;
         end else if (load_hold) begin
            dout <= shadow;
         end
         // a load refills the slot even when the old block leaves at the same edge
         out_valid <= load_in || load_hold || (out_valid && !out_ready);
      end
   end
`ifdef DESER_BLKCNT_EN
   always_ff @(posedge clk)
      if (reset) blk_cnt <= '0;
      else if (out_valid && out_ready) blk_cnt <= blk_cnt + 16'd1;
`endif
   assign dout0 = dout[0];
   assign dout1 = dout[1];
   assign dout2 = dout[2];
   assign dout3 = dout[3];
   assign dout4 = dout[4];
   assign dout5 = dout[5];
   assign dout6 = dout[6];
   assign dout7 = dout[7];
endmodule

// File: tb/tb_sample_deserializer.sv
// tb_sample_deserializer: directed and random checks of sample_deserializer against a block-queue model.
module tb_sample_deserializer;
   localparam int DW = 12;
   typedef logic [8*DW-1:0] blk_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic [DW-1:0] din = '0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [DW-1:0] dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7;
`ifdef DESER_BLKCNT_EN
   logic [15:0] blk_cnt;
`endif
   int checks = 0;
   int errors = 0;
   int ndel = 0;
   logic [DW-1:0] part [$];
   blk_t blocks [$];
   sample_deserializer #(.DW(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .din(din),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
      .dout4(dout4), .dout5(dout5), .dout6(dout6), .dout7(dout7)
`ifdef DESER_BLKCNT_EN
      , .blk_cnt(blk_cnt)
`endif
   );
   always #5 clk = ~clk;
   function automatic blk_t pack();
      return {dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7};
   endfunction
   function automatic blk_t seq(input logic [DW-1:0] base);
      blk_t r = '0;
      for (int i = 0; i < 8; i++) r = (r << DW) | blk_t'(base + DW'(i));
      return r;
   endfunction
   task automatic chk(input string tag, input blk_t obs, input blk_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // One clock cycle: drive inputs, compare against the model, update the model, advance.
   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
      blk_t r;
      in_valid = iv;
      din = d;
      out_ready = ordy;
      #1;
      chk("out_valid", blk_t'(out_valid), blk_t'(blocks.size() > 0));
      chk("in_ready", blk_t'(in_ready), blk_t'(blocks.size() < 2));
      if (out_valid && out_ready) begin
         ndel++;
         if (blocks.size() > 0) chk("block_data", pack(), blocks.pop_front());
      end
      if (iv && in_ready) begin
         part.push_back(d);
         if (part.size() == 8) begin
            r = '0;
            foreach (part[i]) r = (r << DW) | blk_t'(part[i]);
            blocks.push_back(r);
            part.delete();
         end
      end
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      din = '0;
      @(negedge clk);
      chk("rst_out_valid", blk_t'(out_valid), '0);
      chk("rst_dout", pack(), '0);
      reset = 1'b0;
      part.delete();
      blocks.delete();
      @(negedge clk);
      chk("post_rst_out_valid", blk_t'(out_valid), '0);
      chk("post_rst_dout", pack(), '0);
      chk("post_rst_in_ready", blk_t'(in_ready), blk_t'(1));
   endtask
   initial begin
      int n0;
      blk_t held;
      logic [DW-1:0] v;
      @(negedge clk);
      do_reset();
      // stream: 0x001..0x008 with out_ready high
      for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1);
      chk("stream_dout", pack(), seq(12'h001));
      chk("stream_valid", blk_t'(out_valid), blk_t'(1));
      cycle(1'b0, '0, 1'b1);
      // backpressure: 16 samples with out_ready low
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, DW'(12'h100 + i), 1'b0);
      chk("bp_first_dout", pack(), seq(12'h100));
      chk("bp_in_ready", blk_t'(in_ready), '0);
      held = pack();
      cycle(1'b1, 12'hBAD, 1'b0);
      cycle(1'b1, 12'hBAD, 1'b0);
      chk("bp_stable", pack(), held);
      cycle(1'b1, 12'hBAD, 1'b1);
      chk("bp_second_dout", pack(), seq(12'h108));
      chk("bp_second_valid", blk_t'(out_valid), blk_t'(1));
      cycle(1'b0, '0, 1'b1);
      // back-to-back: 24 samples, continuous flow
      do_reset();
      n0 = ndel;
      for (int i = 0; i < 24; i++) cycle(1'b1, DW'(i), 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("b2b_blocks", blk_t'(ndel - n0), blk_t'(3));
      // mid-block reset with a pending output block and a partial block
      do_reset();
      for (int i = 0; i < 13; i++) cycle(1'b1, DW'(12'h300 + i), 1'b0);
      chk("mid_pending", blk_t'(out_valid), blk_t'(1));
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, DW'(12'hA00 + i), 1'b0);
      chk("mid_first_block", pack(), seq(12'hA00));
      cycle(1'b0, '0, 1'b1);
      // random gaps and full-scale values
      do_reset();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: v = 12'hFFF;
            1: v = 12'h800;
            default: v = DW'($urandom_range(0, 4095));
         endcase
         cycle(1'($urandom_range(0, 2) != 0), v, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      chk("rand_drained", blk_t'(blocks.size()), '0);
`ifdef DESER_BLKCNT_EN
      do_reset();
      for (int i = 0; i < 24; i++) cycle(1'b1, DW'(i), 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("blkcnt_three", blk_t'(blk_cnt), blk_t'(3));
      force dut.blk_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.blk_cnt;
      for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("blkcnt_wrap", blk_t'(blk_cnt), '0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
